// File: rtl/network_bank_out.sv
// Gather stage of a banked memory network: routes each bank's read word back to
// the lane that addressed it, RD_LAT cycles after the request, with sticky error flags.
`ifndef P
`define P 2
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef MAP
`define MAP 3
`endif

module network_bank_out #(
    parameter int N_LANES = 2*`P,
    parameter int W       = `DATA_WIDTH,
    parameter int SELW    = `MAP,
    parameter int RD_LAT  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [N_LANES*SELW-1:0] BI_bus,
    input  logic [N_LANES*W-1:0]   bank_data_bus,
    input  logic                   err_clr,
    output logic                   out_valid,
    output logic [N_LANES*W-1:0]   out_data_bus,
    output logic                   conflict_err,
    output logic                   range_err
);

    logic [RD_LAT-1:0]        vld_pipe_q;
    logic [N_LANES*SELW-1:0]  bi_pipe_q [RD_LAT];
    logic [N_LANES*SELW-1:0]  bi_del_s;
    logic                     vld_del_s;
    logic [N_LANES*W-1:0]     gather_d;
    logic                     conflict_d;
    logic                     range_d;
    logic                     out_valid_q;
    logic [N_LANES*W-1:0]     out_data_q;
    logic                     conflict_q;
    logic                     range_q;

    assign bi_del_s  = bi_pipe_q[RD_LAT-1];
    assign vld_del_s = vld_pipe_q[RD_LAT-1];

    // Request pipeline: bank indices travel alongside the bank read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                bi_pipe_q[k] <= '0;
            end
        end else begin
            vld_pipe_q[0] <= in_valid;
            bi_pipe_q[0]  <= BI_bus;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_pipe_q[k] <= vld_pipe_q[k-1];
                bi_pipe_q[k]  <= bi_pipe_q[k-1];
            end
        end
    end

    // Gather mux: an out-of-range index matches no bank, leaving the lane at zero.
    always_comb begin
        gather_d = '0;
        for (int i = 0; i < N_LANES; i++) begin
            for (int b = 0; b < N_LANES; b++) begin
                gather_d[i*W +: W] = gather_d[i*W +: W] |
                    ({W{{1'b0, bi_del_s[i*SELW +: SELW]} == (SELW+1)'(b)}} & bank_data_bus[b*W +: W]);
            end
        end
    end

    // Error detection on the incoming request, widened so N_LANES == 2**SELW still compares correctly.
    always_comb begin
        conflict_d = 1'b0;
        range_d    = 1'b0;
        for (int i = 0; i < N_LANES; i++) begin
            range_d = range_d | ({1'b0, BI_bus[i*SELW +: SELW]} >= (SELW+1)'(N_LANES));
            for (int j = i + 1; j < N_LANES; j++) begin
                conflict_d = conflict_d | (BI_bus[i*SELW +: SELW] == BI_bus[j*SELW +: SELW]);
            end
        end
        conflict_d = conflict_d & in_valid;
        range_d    = range_d & in_valid;
    end

    // Output register and sticky flags; a fresh error outranks err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            conflict_q  <= 1'b0;
            range_q     <= 1'b0;
        end else begin
            out_valid_q <= vld_del_s;
            if (vld_del_s) begin
                out_data_q <= gather_d;
            end else begin
                out_data_q <= out_data_q;
            end
            conflict_q <= conflict_d | (conflict_q & ~err_clr);
            range_q    <= range_d | (range_q & ~err_clr);
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data_bus = out_data_q;
    assign conflict_err = conflict_q;
    assign range_err    = range_q;

endmodule

// File: doc/network_bank_out.md
NETWORK_BANK_OUT -- requirements
Module: network_bank_out

Interface
REQ-001 SHALL have parameter N_LANES, default 2*`P, number of lanes and banks (gather width).
REQ-002 SHALL have parameter W, default `DATA_WIDTH, per-bank data word width.
REQ-003 SHALL have parameter SELW, default `MAP, bank-index width per lane.
REQ-004 SHALL have parameter RD_LAT, default 1, bank read latency in cycles (legal range 1..8).
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1, request issued to banks this cycle.
REQ-008 SHALL have port BI_bus, input, N_LANES*SELW, per-lane bank index; lane i in bits [i*SELW +: SELW].
REQ-009 SHALL have port bank_data_bus, input, N_LANES*W, bank read data; bank b in bits [b*W +: W].
REQ-010 SHALL have port err_clr, input, 1, clears the sticky error flags.
REQ-011 SHALL have port out_valid, output, 1, out_data_bus holds a gathered result.
REQ-012 SHALL have port out_data_bus, output, N_LANES*W, gathered data; lane i in bits [i*W +: W].
REQ-013 SHALL have port conflict_err, output, 1, sticky flag: two lanes addressed the same bank.
REQ-014 SHALL have port range_err, output, 1, sticky flag: a lane's index was >= N_LANES.

Function
REQ-015 SHALL capture BI_bus and in_valid into an RD_LAT-deep shift pipeline every cycle, with no stall and no backpressure.
REQ-016 SHALL sample bank_data_bus exactly RD_LAT cycles after the matching in_valid, using the BI captured RD_LAT cycles earlier.
REQ-017 SHALL compute lane i as bank_data_bus[BI_d[i]] (gather, inverse of the address scatter) and register the result; out_valid and out_data_bus update RD_LAT+1 cycles after in_valid.
REQ-018 SHALL accept back-to-back in_valid every cycle; each request emerges in order with no bubbles.
REQ-019 SHALL drive a lane to zero when its delayed index is >= N_LANES.
REQ-020 SHALL hold out_data_bus unchanged when the delayed valid is 0; out_valid SHALL be 0 in that cycle.
REQ-021 SHALL set conflict_err one cycle after an in_valid cycle in which two or more lanes carry equal BI values; duplicate lanes still receive the same bank word.
REQ-022 SHALL set range_err one cycle after an in_valid cycle containing any BI >= N_LANES.
REQ-023 SHALL treat err_clr as clearing both flags on the next edge; a simultaneous new error SHALL win, leaving the flag set.
REQ-024 SHALL ignore BI_bus content when in_valid is 0, both for errors and for data.

Reset
REQ-025 SHALL, while rst is high, asynchronously force all pipeline valid bits, out_valid, conflict_err and range_err to 0, and out_data_bus to all zeros.
REQ-026 SHALL discard requests in flight when rst is asserted mid-operation; no out_valid SHALL appear for them after release.
REQ-027 SHALL accept a new in_valid on the first rising edge after rst deasserts.

Verification
REQ-028 SHALL pass this scenario: N=4, W=8, RD_LAT=1; BI={3,2,1,0} (lane0..3) with in_valid at cycle 0; banks={0x10,0x11,0x12,0x13} at cycle 1 -> cycle 2 out_valid=1, lanes={0x13,0x12,0x11,0x10}, no errors.
REQ-029 SHALL pass this scenario: RD_LAT=3; three back-to-back requests with identity, reverse and rotate-by-1 indices -> three consecutive out_valid cycles starting at cycle 4, each correctly gathered.
REQ-030 SHALL pass this scenario: BI={1,1,2,3} with in_valid -> conflict_err=1 next cycle; lanes0,1 both equal bank1 data; err_clr alone -> 0 next cycle.
REQ-031 SHALL pass this scenario: BI lane2=5 with N=4 -> range_err=1 and lane2 output 0x00; err_clr concurrent with another range error -> flag stays 1.
REQ-032 SHALL pass this scenario: rst pulsed asynchronously one cycle after in_valid (RD_LAT=2) -> outputs zero immediately, no out_valid afterwards, next request after release completes normally.
REQ-033 SHALL pass this scenario: in_valid=0 with BI={0,0,0,0} -> no conflict_err, out_valid stays 0, out_data_bus holds its previous value.
